// File: rtl/serial_digit_adder_pkg.sv
// Shared definitions for the digit-serial add/subtract unit.
//   state_t    : FSM encoding (ST_IDLE, ST_RUN)
//   n_digits   : number of digits per operand (W/D)
//   cnt_width  : digit counter width, clog2(N) with a floor of 1
package serial_digit_adder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int n_digits(input int w, input int d);
    return w / d;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_digit_adder_digit_adder.sv
// digit_adder: combinational D-bit ripple of full-adder cells.
//   i_x, i_y [D-1:0] : digit operands
//   i_ci             : carry into bit 0
//   o_s  [D-1:0]     : digit sum
//   o_co             : carry out of bit D-1
//   o_cmsb           : carry into bit D-1 (feeds the overflow detect)
module digit_adder #(
  parameter int D = 1
) (
  input  logic [D-1:0] i_x,
  input  logic [D-1:0] i_y,
  input  logic         i_ci,
  output logic [D-1:0] o_s,
  output logic         o_co,
  output logic         o_cmsb
);

  logic [D:0] w_c;

  assign w_c[0] = i_ci;

  for (genvar k = 0; k < D; k++) begin : g_fa
    assign o_s[k]     = i_x[k] ^ i_y[k] ^ w_c[k];
    assign w_c[k+1]   = (i_x[k] & i_y[k]) | (w_c[k] & (i_x[k] ^ i_y[k]));
  end

  assign o_co   = w_c[D];
  assign o_cmsb = w_c[D-1];

endmodule

// File: rtl/serial_digit_adder.sv
// serial_digit_adder: multi-cycle add/subtract, D bits per clock, LSB first,
// N = W/D RUN cycles per operation.
//   i_clk, i_rst_n : clock (rising edge), async active-low reset
//   i_start        : request, sampled only while idle
//   i_sub          : 0 -> A+B, 1 -> A-B (A + ~B + 1); latched with i_start
//   i_a, i_b [W]   : operands, latched with i_start
//   o_busy         : operation in progress
//   o_done         : one-cycle pulse, o_s/o_co/o_ov valid
//   o_s [W]        : result, held until the next operation's final edge
//   o_co           : carry out of the MSB (subtract: 1 = no borrow)
//   o_ov           : two's-complement overflow
module serial_digit_adder
  import serial_digit_adder_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_sub,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_s,
  output logic         o_co,
  output logic         o_ov
);

  localparam int N  = n_digits(W, D);
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (W < 2 || D < 1 || D > W || (W % D) != 0) begin : g_bad_param
    $error("serial_digit_adder: need W >= 2, 1 <= D <= W, W %% D == 0");
  end

  state_t         r_state;
  logic [W-1:0]   r_opa;
  logic [W-1:0]   r_opb;
  logic [W-1:0]   r_acc;
  logic [CW-1:0]  r_cnt;
  logic           r_carry;
  logic           r_busy;
  logic           r_done;
  logic [W-1:0]   r_s;
  logic           r_co;
  logic           r_ov;

  logic [D-1:0]   w_sum;
  logic           w_co;
  logic           w_cmsb;
  logic [W-1:0]   w_acc_nxt;

  digit_adder #(.D(D)) u_digit (
    .i_x    (r_opa[D-1:0]),
    .i_y    (r_opb[D-1:0]),
    .i_ci   (r_carry),
    .o_s    (w_sum),
    .o_co   (w_co),
    .o_cmsb (w_cmsb)
  );

  // New digit enters at the MSB end; after N digits the LSB digit has
  // reached bit 0. Written as shift/or so D == W needs no special case.
  assign w_acc_nxt = (r_acc >> D) | (W'(w_sum) << (W - D));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_ov    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_opa   <= i_a;
            r_opb   <= i_sub ? ~i_b : i_b;
            r_carry <= i_sub;            // the +1 of two's-complement negate
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_opa   <= r_opa >> D;
          r_opb   <= r_opb >> D;
          r_acc   <= w_acc_nxt;
          r_carry <= w_co;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_s     <= w_acc_nxt;
            r_co    <= w_co;
            // last digit's carry into bit D-1 is the carry into bit W-1
            r_ov    <= w_cmsb ^ w_co;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_s    = r_s;
  assign o_co   = r_co;
  assign o_ov   = r_ov;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Self-checking bench: five configurations (8/1, 8/4, 8/2, 16/8, 4/4) checked
// against an arithmetic reference model.
module tb_serial_digit_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  start;
  logic        sub;
  logic [15:0] a, b;
  logic [4:0]  busy, done, co, ov;
  logic [7:0]  s0, s1, s2;
  logic [15:0] s3;
  logic [3:0]  s4;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  serial_digit_adder #(.W(8), .D(1)) u0 (.i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]),
    .i_sub(sub), .i_a(a[7:0]), .i_b(b[7:0]), .o_busy(busy[0]), .o_done(done[0]),
    .o_s(s0), .o_co(co[0]), .o_ov(ov[0]));
  serial_digit_adder #(.W(8), .D(4)) u1 (.i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]),
    .i_sub(sub), .i_a(a[7:0]), .i_b(b[7:0]), .o_busy(busy[1]), .o_done(done[1]),
    .o_s(s1), .o_co(co[1]), .o_ov(ov[1]));
  serial_digit_adder #(.W(8), .D(2)) u2 (.i_clk(clk), .i_rst_n(rst_n), .i_start(start[2]),
    .i_sub(sub), .i_a(a[7:0]), .i_b(b[7:0]), .o_busy(busy[2]), .o_done(done[2]),
    .o_s(s2), .o_co(co[2]), .o_ov(ov[2]));
  serial_digit_adder #(.W(16), .D(8)) u3 (.i_clk(clk), .i_rst_n(rst_n), .i_start(start[3]),
    .i_sub(sub), .i_a(a), .i_b(b), .o_busy(busy[3]), .o_done(done[3]),
    .o_s(s3), .o_co(co[3]), .o_ov(ov[3]));
  serial_digit_adder #(.W(4), .D(4)) u4 (.i_clk(clk), .i_rst_n(rst_n), .i_start(start[4]),
    .i_sub(sub), .i_a(a[3:0]), .i_b(b[3:0]), .o_busy(busy[4]), .o_done(done[4]),
    .o_s(s4), .o_co(co[4]), .o_ov(ov[4]));

  function automatic logic [15:0] s_of(input int i);
    case (i)
      0: return 16'(s0);
      1: return 16'(s1);
      2: return 16'(s2);
      3: return s3;
      default: return 16'(s4);
    endcase
  endfunction

  function automatic int w_of(input int i);
    case (i)
      3: return 16;
      4: return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int n_of(input int i);
    case (i)
      0: return 8;
      1: return 2;
      2: return 4;
      3: return 2;
      default: return 1;
    endcase
  endfunction

  // {ov, co, s}: plain integer add, overflow from operand/result signs
  function automatic logic [17:0] model(input int w, input logic [15:0] ia,
                                       input logic [15:0] ib, input logic isub);
    longint mask, aa, bb, sum, s;
    logic   c, v;
    mask = (longint'(1) << w) - 1;
    aa   = longint'(ia) & mask;
    bb   = longint'(isub ? ~ib : ib) & mask;
    sum  = aa + bb + longint'(isub);
    s    = sum & mask;
    c    = ((sum >> w) & 1) != 0;
    v    = (((aa >> (w-1)) & 1) == ((bb >> (w-1)) & 1)) &&
           (((s >> (w-1)) & 1) != ((aa >> (w-1)) & 1));
    return {v, c, 16'(s)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Call at a negedge; returns at the negedge where DONE is seen (or on timeout).
  // stray=1 pulses START with a different A at RUN cycle 3 (must be ignored).
  task automatic run_op(input int i, input logic [15:0] ia, input logic [15:0] ib,
                        input logic isub, input bit stray);
    logic [17:0] exp;
    logic [15:0] prev;
    int cyc, bcnt;
    exp  = model(w_of(i), ia, ib, isub);
    prev = s_of(i);
    a = ia; b = ib; sub = isub; start[i] = 1'b1;
    @(negedge clk);
    cyc = 1; bcnt = 0;
    while (!done[i] && cyc < 200) begin
      if (busy[i]) bcnt++;
      if (cyc == 1) chk("hold_s", 32'(s_of(i)), 32'(prev));
      if (stray && cyc == 3) begin
        start[i] = 1'b1; a = 16'h00F0;
      end else begin
        start[i] = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    start[i] = 1'b0;
    chk("latency", 32'(cyc), 32'(n_of(i) + 1));
    chk("busy_cycles", 32'(bcnt), 32'(n_of(i)));
    chk("busy_at_done", 32'(busy[i]), 32'd0);
    chk("result", 32'({ov[i], co[i], s_of(i)}), 32'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic seen_done;
    start = '0; sub = 1'b0; a = '0; b = '0;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 5; i++)
      chk("reset_state", 32'({busy[i], done[i], co[i], ov[i], s_of(i)}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 8/1: 0x7F + 0x01
    run_op(0, 16'h7F, 16'h01, 1'b0, 1'b0);
    chk("t1_const", 32'({ov[0], co[0], s0}), 32'h2_80);
    @(negedge clk);
    chk("done_pulse_width", 32'(done[0]), 32'd0);

    // 8/1 subtract
    run_op(0, 16'h00, 16'h01, 1'b1, 1'b0);
    chk("t2a_const", 32'({ov[0], co[0], s0}), 32'h0_FF);
    @(negedge clk);
    run_op(0, 16'h80, 16'h01, 1'b1, 1'b0);
    chk("t2b_const", 32'({ov[0], co[0], s0}), 32'h3_7F);
    @(negedge clk);

    // 8/4: two RUN cycles
    run_op(1, 16'hFF, 16'h01, 1'b0, 1'b0);
    chk("t3_const", 32'({ov[1], co[1], s1}), 32'h1_00);
    @(negedge clk);

    // 8/1: ignored mid-run START, then back-to-back START in the DONE cycle
    run_op(0, 16'h05, 16'h03, 1'b0, 1'b1);
    chk("t4_ignored", 32'(s0), 32'h08);
    run_op(0, 16'h10, 16'h10, 1'b0, 1'b0);
    chk("t4_b2b", 32'(s0), 32'h20);
    @(negedge clk);

    // 8/2: reset mid-run
    run_op(2, 16'hAA, 16'h11, 1'b0, 1'b0);
    @(negedge clk);
    a = 16'h12; b = 16'h34; sub = 1'b0; start[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy[2]), 32'd0);
    chk("rst_mid_done", 32'(done[2]), 32'd0);
    chk("rst_mid_s", 32'({ov[2], co[2], s2}), 32'd0);
    seen_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done[2]) seen_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done[2]) seen_done = 1'b1;
    end
    chk("rst_no_done", 32'(seen_done), 32'd0);
    run_op(2, 16'h12, 16'h34, 1'b0, 1'b0);
    chk("t5_const", 32'(s2), 32'h46);
    @(negedge clk);

    // random: 16/8 and 4/4
    for (int k = 0; k < 200; k++) begin
      run_op(3, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
      @(negedge clk);
      run_op(4, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
      if (k[0]) @(negedge clk);
    end
    // a few random ops on the other shapes
    for (int k = 0; k < 20; k++) begin
      run_op(k % 3, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
